// File: rtl/fpu_issue_pkg.sv
// Shared types, opcode constants and the opcode decoder for the FPU issue controller.
package fpu_issue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALU  = 2'd1,
    SFU  = 2'd2,
    DS   = 2'd3
  } unit_e;

  localparam int unsigned LAT_W = 4;

  localparam logic [5:0] OP_DS0    = 6'h24;
  localparam logic [5:0] OP_DS1    = 6'h25;
  localparam logic [5:0] OP_SFU1_0 = 6'h27;
  localparam logic [5:0] OP_SFU1_1 = 6'h2A;

  typedef struct packed {
    unit_e            unit;
    logic [LAT_W-1:0] lat;
  } dec_t;

  // The opcode arrives zero-extended to 16 bits; opcode_w locates the class bit.
  function automatic dec_t decode_op(input logic [15:0] opcode, input int unsigned opcode_w,
                                     input int unsigned lat_sfu, input int unsigned lat_ds);
    dec_t d;
    if (!opcode[4'(opcode_w - 1)]) begin
      d.unit = ALU;
      d.lat  = LAT_W'(1);
    end else if (opcode == 16'(OP_DS0) || opcode == 16'(OP_DS1)) begin
      d.unit = DS;
      d.lat  = LAT_W'(lat_ds);
    end else if (opcode == 16'(OP_SFU1_0) || opcode == 16'(OP_SFU1_1)) begin
      d.unit = SFU;
      d.lat  = LAT_W'(1);
    end else begin
      d.unit = SFU;
      d.lat  = LAT_W'(lat_sfu);
    end
    return d;
  endfunction

endpackage

// File: rtl/fpu_issue_if.sv
// Fetch-side handshake and status bundle between the fetch stage and the issue controller.
interface fpu_issue_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 4
);
    logic                inst_valid_i;
    logic [OPCODE_W-1:0] opcode_i;
    logic                stall_i;
    logic                flush_i;
    logic                inst_fetch_en_o;
    logic                alu_data_fetch_en_o;
    logic                sfu_data_fetch_en_o;
    logic                ds_data_fetch_en_o;
    logic                sfu_en_o;
    logic                ds_en_o;
    logic                busy_o;
    logic [CNT_W-1:0]    remain_o;

    modport master (
        output inst_valid_i, opcode_i, stall_i, flush_i,
        input  inst_fetch_en_o, alu_data_fetch_en_o, sfu_data_fetch_en_o,
               ds_data_fetch_en_o, sfu_en_o, ds_en_o, busy_o, remain_o
    );

    modport slave (
        input  inst_valid_i, opcode_i, stall_i, flush_i,
        output inst_fetch_en_o, alu_data_fetch_en_o, sfu_data_fetch_en_o,
               ds_data_fetch_en_o, sfu_en_o, ds_en_o, busy_o, remain_o
    );
endinterface

// File: rtl/fpu_issue_ctrl_lat_counter.sv
// Latency counter: tracks elapsed cycles (cnt_q) against the loaded op latency (lat_q).
module fpu_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             inc,
    input  logic             clear,
    input  logic [CNT_W-1:0] lat_i,
    output logic             last_o,
    output logic [CNT_W-1:0] remain_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lat_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
            lat_q <= lat_i;
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // With lat_q cleared the compare wraps to all-ones, so an idle counter never reports last.
    assign last_o   = (cnt_q == lat_q - CNT_W'(1));
    assign remain_o = lat_q - cnt_q;
endmodule

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: decodes opcodes into ALU/SFU/DS classes, throttles fetch and strobes result capture.
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int LAT_SFU  = 2,
    parameter int LAT_DS   = 5,
    parameter int CNT_W    = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    fpu_issue_if.slave  bus
);
    localparam int LAT_MAX = (LAT_SFU > LAT_DS) ? LAT_SFU : LAT_DS;

    if (LAT_SFU < 2 || LAT_SFU > 15 || LAT_DS < 2 || LAT_DS > 15) begin : g_bad_lat
        $error("fpu_issue_ctrl: LAT_SFU and LAT_DS must lie in 2..15");
    end
    if ((2 ** CNT_W) <= LAT_MAX) begin : g_bad_cnt
        $error("fpu_issue_ctrl: CNT_W too narrow for the configured latencies");
    end
    if (OPCODE_W < 6 || OPCODE_W > 16) begin : g_bad_op
        $error("fpu_issue_ctrl: OPCODE_W must lie in 6..16");
    end

    // State codes are tied to the decoder's unit encoding so a decoded unit loads directly.
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_ALU  = 2'(ALU);
    localparam logic [1:0] ST_SFU  = 2'(SFU);
    localparam logic [1:0] ST_DS   = 2'(DS);

    logic [1:0]       state_q, state_d;
    dec_t             dec;
    logic [CNT_W-1:0] lat_ld;
    logic [CNT_W-1:0] remain;
    logic             last, multi, free, strobe_ok, fetch_en, accept;
    logic             ld, inc, clr;

    assign dec       = decode_op(16'(bus.opcode_i), OPCODE_W, LAT_SFU, LAT_DS);
    assign lat_ld    = CNT_W'(dec.lat);
    assign multi     = (state_q == ST_SFU) || (state_q == ST_DS);
    assign free      = !multi || last;
    assign strobe_ok = !bus.stall_i && !bus.flush_i;
    assign fetch_en  = Reset && free && strobe_ok;
    assign accept    = bus.inst_valid_i && fetch_en;

    // Priority: flush, then stall (hold everything), then accept, then count or retire.
    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        if (bus.flush_i) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
        end else if (bus.stall_i) begin
            state_d = state_q;
        end else if (accept) begin
            state_d = 2'(dec.unit);
            ld      = 1'b1;
        end else if (multi && !last) begin
            inc = 1'b1;
        end else begin
            state_d = ST_IDLE;
            clr     = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    fpu_lat_counter #(.CNT_W(CNT_W)) u_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (ld),
        .inc      (inc),
        .clear    (clr),
        .lat_i    (lat_ld),
        .last_o   (last),
        .remain_o (remain)
    );

    assign bus.inst_fetch_en_o     = fetch_en;
    assign bus.alu_data_fetch_en_o = (state_q == ST_ALU) && strobe_ok;
    assign bus.sfu_data_fetch_en_o = (state_q == ST_SFU) && last && strobe_ok;
    assign bus.ds_data_fetch_en_o  = (state_q == ST_DS)  && last && strobe_ok;
    assign bus.sfu_en_o            = (state_q == ST_SFU) && !last && !bus.flush_i;
    assign bus.ds_en_o             = (state_q == ST_DS)  && !last && !bus.flush_i;
    assign bus.busy_o              = multi && !last;
    assign bus.remain_o            = multi ? remain : '0;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios plus random traffic against a behavioural model.
module tb_fpu_issue_ctrl;
    localparam int OPCODE_W = 6;
    localparam int LAT_SFU  = 2;
    localparam int LAT_DS   = 5;
    localparam int CNT_W    = 4;

    logic Clk;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    // Model: which unit owns the machine (0 none, 1 ALU, 2 SFU, 3 DS) and cycles left.
    int m_unit = 0;
    int m_rem  = 0;

    fpu_issue_if #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) bus ();

    fpu_issue_ctrl #(.OPCODE_W(OPCODE_W), .LAT_SFU(LAT_SFU), .LAT_DS(LAT_DS), .CNT_W(CNT_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_decode(input int op, output int unit, output int lat);
        if (op < 32)                      begin unit = 1; lat = 1;       end
        else if (op == 'h24 || op == 'h25) begin unit = 3; lat = LAT_DS;  end
        else if (op == 'h27 || op == 'h2A) begin unit = 2; lat = 1;       end
        else                              begin unit = 2; lat = LAT_SFU; end
    endfunction

    function automatic int model_free();
        return (m_unit <= 1 || m_rem == 1) ? 1 : 0;
    endfunction

    // Compare every cycle, just after inputs have settled on the falling edge.
    always @(negedge Clk) begin
        int go, fetch;
        #1;
        go    = (!bus.stall_i && !bus.flush_i) ? 1 : 0;
        fetch = (Reset && model_free() == 1 && go == 1) ? 1 : 0;
        if (!Reset) begin
            chk("fetch", bus.inst_fetch_en_o, 0);
            chk("alu_strb", bus.alu_data_fetch_en_o, 0);
            chk("sfu_strb", bus.sfu_data_fetch_en_o, 0);
            chk("ds_strb", bus.ds_data_fetch_en_o, 0);
            chk("sfu_en", bus.sfu_en_o, 0);
            chk("ds_en", bus.ds_en_o, 0);
            chk("busy", bus.busy_o, 0);
            chk("remain", bus.remain_o, 0);
        end else begin
            chk("fetch", bus.inst_fetch_en_o, fetch);
            chk("alu_strb", bus.alu_data_fetch_en_o, (m_unit == 1 && go == 1) ? 1 : 0);
            chk("sfu_strb", bus.sfu_data_fetch_en_o, (m_unit == 2 && m_rem == 1 && go == 1) ? 1 : 0);
            chk("ds_strb", bus.ds_data_fetch_en_o, (m_unit == 3 && m_rem == 1 && go == 1) ? 1 : 0);
            chk("sfu_en", bus.sfu_en_o, (m_unit == 2 && m_rem > 1 && !bus.flush_i) ? 1 : 0);
            chk("ds_en", bus.ds_en_o, (m_unit == 3 && m_rem > 1 && !bus.flush_i) ? 1 : 0);
            chk("busy", bus.busy_o, (m_unit >= 2 && m_rem > 1) ? 1 : 0);
            chk("remain", bus.remain_o, (m_unit >= 2) ? m_rem : 0);
        end
    end

    always @(posedge Clk) begin
        int u, l;
        if (!Reset || bus.flush_i) begin
            m_unit = 0;
            m_rem  = 0;
        end else if (bus.stall_i) begin
            m_unit = m_unit;
        end else if (bus.inst_valid_i && model_free() == 1) begin
            model_decode(int'(bus.opcode_i), u, l);
            m_unit = u;
            m_rem  = l;
        end else if (m_unit >= 2 && m_rem > 1) begin
            m_rem = m_rem - 1;
        end else begin
            m_unit = 0;
            m_rem  = 0;
        end
    end

    task automatic cyc(input logic rst, input logic v, input logic [5:0] op,
                       input logic st, input logic fl);
        @(negedge Clk);
        Reset            = rst;
        bus.inst_valid_i = v;
        bus.opcode_i     = op;
        bus.stall_i      = st;
        bus.flush_i      = fl;
        #2;
    endtask

    initial begin
        Reset            = 1'b0;
        bus.inst_valid_i = 1'b0;
        bus.opcode_i     = '0;
        bus.stall_i      = 1'b0;
        bus.flush_i      = 1'b0;

        repeat (3) cyc(0, 1, 6'h03, 0, 0);
        chk("rst_fetch", bus.inst_fetch_en_o, 0);
        chk("rst_remain", bus.remain_o, 0);

        // ALU stream
        cyc(1, 1, 6'h03, 0, 0); chk("t1_fetch0", bus.inst_fetch_en_o, 1); chk("t1_alu0", bus.alu_data_fetch_en_o, 0);
        cyc(1, 1, 6'h05, 0, 0); chk("t1_alu1", bus.alu_data_fetch_en_o, 1); chk("t1_fetch1", bus.inst_fetch_en_o, 1);
        cyc(1, 1, 6'h07, 0, 0); chk("t1_alu2", bus.alu_data_fetch_en_o, 1);
        cyc(1, 0, 6'h00, 0, 0); chk("t1_alu3", bus.alu_data_fetch_en_o, 1);
        cyc(1, 0, 6'h00, 0, 0); chk("t1_idle", bus.alu_data_fetch_en_o, 0);

        // SFU LAT_SFU=2 followed by ALU
        cyc(1, 1, 6'h21, 0, 0); chk("t2_fetch_t", bus.inst_fetch_en_o, 1);
        cyc(1, 1, 6'h02, 0, 0); chk("t2_sfu_en", bus.sfu_en_o, 1); chk("t2_fetch_t1", bus.inst_fetch_en_o, 0);
        chk("t2_remain", bus.remain_o, 2);
        cyc(1, 1, 6'h02, 0, 0); chk("t2_sfu_strb", bus.sfu_data_fetch_en_o, 1); chk("t2_fetch_t2", bus.inst_fetch_en_o, 1);
        cyc(1, 0, 6'h00, 0, 0); chk("t2_alu", bus.alu_data_fetch_en_o, 1);

        // DS countdown
        cyc(1, 1, 6'h24, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 6'h00, 0, 0);
            chk("t3_ds_en", bus.ds_en_o, 1);
            chk("t3_remain", bus.remain_o, 5 - i);
        end
        cyc(1, 0, 6'h00, 0, 0); chk("t3_strb", bus.ds_data_fetch_en_o, 1); chk("t3_rem1", bus.remain_o, 1);
        chk("t3_busy", bus.busy_o, 0);
        cyc(1, 0, 6'h00, 0, 0); chk("t3_strb_off", bus.ds_data_fetch_en_o, 0); chk("t3_rem0", bus.remain_o, 0);

        // Back-to-back latency-1 SFU ops
        cyc(1, 1, 6'h27, 0, 0);
        cyc(1, 1, 6'h2A, 0, 0); chk("t4_strb0", bus.sfu_data_fetch_en_o, 1); chk("t4_fetch", bus.inst_fetch_en_o, 1);
        chk("t4_en0", bus.sfu_en_o, 0);
        cyc(1, 0, 6'h00, 0, 0); chk("t4_strb1", bus.sfu_data_fetch_en_o, 1); chk("t4_en1", bus.sfu_en_o, 0);
        cyc(1, 0, 6'h00, 0, 0); chk("t4_done", bus.sfu_data_fetch_en_o, 0);

        // Stall across the DS final phase
        cyc(1, 1, 6'h24, 0, 0);
        repeat (4) cyc(1, 0, 6'h00, 0, 0);
        repeat (3) begin
            cyc(1, 0, 6'h00, 1, 0);
            chk("t5_strb_stall", bus.ds_data_fetch_en_o, 0);
            chk("t5_rem_stall", bus.remain_o, 1);
            chk("t5_fetch_stall", bus.inst_fetch_en_o, 0);
        end
        cyc(1, 0, 6'h00, 0, 0); chk("t5_strb", bus.ds_data_fetch_en_o, 1);
        cyc(1, 0, 6'h00, 0, 0); chk("t5_strb_once", bus.ds_data_fetch_en_o, 0);

        // Flush at cnt_q=2 of DS
        cyc(1, 1, 6'h24, 0, 0);
        repeat (2) cyc(1, 0, 6'h00, 0, 0);
        cyc(1, 1, 6'h03, 0, 1); chk("t6_fl_ds_en", bus.ds_en_o, 0); chk("t6_fl_fetch", bus.inst_fetch_en_o, 0);
        chk("t6_fl_strb", bus.ds_data_fetch_en_o, 0);
        cyc(1, 0, 6'h00, 0, 0); chk("t6_fl_rem", bus.remain_o, 0); chk("t6_fl_busy", bus.busy_o, 0);

        // Reset at cnt_q=1 of SFU
        cyc(1, 1, 6'h21, 0, 0);
        cyc(1, 0, 6'h00, 0, 0); chk("t6_sfu_en", bus.sfu_en_o, 1);
        cyc(0, 1, 6'h03, 0, 0); chk("t6_rst_strb", bus.sfu_data_fetch_en_o, 0); chk("t6_rst_fetch", bus.inst_fetch_en_o, 0);
        chk("t6_rst_en", bus.sfu_en_o, 0);
        cyc(1, 0, 6'h00, 0, 0); chk("t6_post_strb", bus.sfu_data_fetch_en_o, 0); chk("t6_post_rem", bus.remain_o, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            int r;
            r = int'($urandom_range(0, 7));
            if (r <= 2)      op = 6'($urandom_range(0, 31));
            else if (r == 3) op = ($urandom_range(0, 1) == 0) ? 6'h24 : 6'h25;
            else if (r == 4) op = ($urandom_range(0, 1) == 0) ? 6'h27 : 6'h2A;
            else             op = 6'($urandom_range(32, 63));
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), op,
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5));
        end
        repeat (20) cyc(1, 0, 6'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Parametrised instruction-issue controller for the FPU.
- Decodes each incoming opcode into a unit class: ALU, SFU single-cycle, SFU multi-cycle, or DS (divide/sqrt).
- Throttles instruction fetch while a multi-cycle unit is busy.
- Raises a one-cycle data-fetch strobe for the owning unit when its result is ready.
- Adds over the previous generation: configurable latencies, an instruction valid qualifier, synchronous flush, remaining-cycle and busy status, and stall-safe strobes. Sits between the fetch stage and the ALU/SFU/DS datapaths.

Parameters:
- OPCODE_W, 6, opcode width; bit OPCODE_W-1 set means SFU/DS class.
- LAT_SFU, 2, cycles for multi-cycle SFU ops; legal range 2..15.
- LAT_DS, 5, cycles for DS ops (6'h24, 6'h25); legal range 2..15.
- CNT_W, 4, counter width; elaboration error if 2**CNT_W <= max(LAT_SFU, LAT_DS).

Ports:
- Clk  in  1  clock
- Reset  in  1  reset, asynchronous, active-low
- inst_valid_i  in  1  opcode_i carries a valid instruction
- opcode_i  in  OPCODE_W  current instruction opcode
- stall_i  in  1  load/store freeze; holds all state
- flush_i  in  1  synchronous abort of the in-flight operation
- inst_fetch_en_o  out  1  controller can accept; accept = inst_valid_i & inst_fetch_en_o
- alu_data_fetch_en_o  out  1  ALU result capture
- sfu_data_fetch_en_o  out  1  SFU result capture strobe
- ds_data_fetch_en_o  out  1  DS result capture strobe
- sfu_en_o  out  1  SFU computing
- ds_en_o  out  1  DS computing
- busy_o  out  1  multi-cycle op in flight
- remain_o  out  CNT_W  cycles left including the current one; 0 when not busy

Behaviour:

Decode
- opcode MSB=0 → ALU.
- 6'h24 or 6'h25 → DS, latency LAT_DS.
- 6'h27 or 6'h2A → SFU with latency 1.
- Any other opcode with MSB=1 → SFU, latency LAT_SFU.
- On accept, the decoded latency is loaded into lat_q and cnt_q is cleared.

States: IDLE, ALU, SFU, DS. Reset enters IDLE with cnt_q=0 and lat_q=0.

IDLE
- inst_fetch_en_o = !stall_i & !flush_i.
- On accept, go to the decoded state; otherwise stay in IDLE.

ALU
- alu_data_fetch_en_o = !stall_i.
- inst_fetch_en_o = !stall_i & !flush_i.
- On accept, go to the decoded state; otherwise go to IDLE.

SFU / DS, counting phase (cnt_q < lat_q-1)
- Unit enable (sfu_en_o or ds_en_o) = 1.
- inst_fetch_en_o = 0.
- cnt_q increments each unstalled cycle.

SFU / DS, final phase (cnt_q == lat_q-1)
- Unit enable = 0.
- Owning data_fetch_en = !stall_i, a single-cycle pulse.
- inst_fetch_en_o = !stall_i & !flush_i, so back-to-back issue is possible.
- Next state is the decoded state if an instruction is accepted; otherwise IDLE.
- A latency-1 SFU op lands directly in this phase: no sfu_en_o cycle, one strobe cycle.

Timing
- An op accepted at cycle t produces its data_fetch strobe at cycle t+lat.
- For an ALU op, lat=1.

Status outputs
- busy_o = (state in SFU/DS) & (cnt_q < lat_q-1).
- remain_o = lat_q - cnt_q in SFU/DS, else 0.

stall_i (flush_i = 0)
- State, cnt_q and lat_q hold.
- All data_fetch strobes and inst_fetch_en_o are forced to 0.
- sfu_en_o and ds_en_o hold their value.
- On release, the strobe appears exactly once.

flush_i
- Priority: flush over stall over accept.
- Next cycle: IDLE, cnt_q=0, lat_q=0.
- No strobe and no accept during the flush cycle; unit enables are forced to 0 in that cycle.

Reset
- While Reset is low, every output is 0, including inst_fetch_en_o, which is gated by Reset.
- Reset asserted mid-operation aborts it with no strobe.

Unknown state encodings recover to IDLE.

Decomposition:
- Package fpu_issue_pkg holds:
  - unit_e enum {IDLE, ALU, SFU, DS};
  - opcode constants OP_DS0=6'h24, OP_DS1=6'h25, OP_SFU1_0=6'h27, OP_SFU1_1=6'h2A;
  - function decode_op(opcode, LAT_SFU, LAT_DS) returning unit and latency.
- One sub-module, fpu_lat_counter: holds cnt_q and lat_q; load/enable/clear inputs; last and remain outputs.

Test Plan:
1. ALU stream: opcodes 6'h03, 6'h05, 6'h07 valid on consecutive cycles → inst_fetch_en_o=1 throughout; alu_data_fetch_en_o=1 in the three cycles after each accept; then IDLE.
2. SFU 6'h21 with LAT_SFU=2 accepted at t, then 6'h02 valid → sfu_en_o=1 at t+1; sfu_data_fetch_en_o=1 and inst_fetch_en_o=1 at t+2; 6'h02 accepted at t+2; ALU strobe at t+3.
3. DS 6'h24 with LAT_DS=5 → ds_en_o=1 for 4 cycles; remain_o counts 5,4,3,2,1; ds_data_fetch_en_o single pulse at t+5; busy_o=0 in the pulse cycle.
4. 6'h27 followed immediately by 6'h2A → each yields one sfu_data_fetch_en_o pulse; sfu_en_o never asserts; no fetch bubble.
5. DS op with stall_i held 3 cycles during the final phase → ds_data_fetch_en_o=0 while stalled, exactly one pulse after release; remain_o frozen at 1.
6. Flush at cnt_q=2 of DS, and Reset low at cnt_q=1 of SFU → state IDLE next cycle; no data strobe; all outputs 0 during reset.
